// File: rtl/move_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : move_controller_if
// Brief    : Click handshake and move-logic link of the chess move controller
// Revision : 1.0
// ============================================================================
interface move_controller_if;
    logic        click_valid;
    logic        click_ready;
    logic [5:0]  click_pos;
    logic [63:0] possible_moves;
    logic [4:0]  selected_figure;
    logic [5:0]  position;

    modport master (
        output click_valid,
        output click_pos,
        output possible_moves,
        input  click_ready,
        input  selected_figure,
        input  position
    );

    modport slave (
        input  click_valid,
        input  click_pos,
        input  possible_moves,
        output click_ready,
        output selected_figure,
        output position
    );
endinterface
`default_nettype wire

// File: rtl/move_controller.sv
`default_nettype none
// ============================================================================
// Module   : move_controller
// Brief    : Turn/selection FSM and sole owner of the chess board register
// Revision : 1.0
// ============================================================================
module move_controller #(
    parameter int unsigned EVAL_CYCLES = 1,
    parameter logic [2:0]  PROMO_TYPE  = 3'd5
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              new_game,
    move_controller_if.slave       bus,
    output logic [7:0][7:0][3:0]   board,
    output logic [63:0]            move_mask,
    output logic                   turn,
    output logic                   move_done,
    output logic                   illegal,
    output logic [7:0]             move_count
);

    typedef enum logic [1:0] {
        ST_WAIT_SRC = 2'd0,
        ST_EVAL     = 2'd1,
        ST_WAIT_DST = 2'd2,
        ST_COMMIT   = 2'd3
    } state_t;

    localparam logic [3:0] EVAL_LOAD = 4'(EVAL_CYCLES - 1);

    state_t      state;
    logic [5:0]  src_pos;
    logic [3:0]  src_code;
    logic [5:0]  dst_pos;
    logic [3:0]  eval_cnt;
    logic [4:0]  sel_figure;
    logic [5:0]  sel_position;

    logic [63:0] own_mask;
    logic [3:0]  click_code;
    logic        click_own;
    logic        click_accept;
    logic        promote;
    logic [3:0]  commit_code;

    function automatic logic [7:0][7:0][3:0] initial_board();
        logic [7:0][7:0][3:0] b;
        logic [2:0]           back;
        b = '0;
        for (int c = 0; c < 8; c++) begin
            case (c)
                0, 7:    back = 3'd2;
                1, 6:    back = 3'd3;
                2, 5:    back = 3'd4;
                3:       back = 3'd5;
                default: back = 3'd6;
            endcase
            b[0][c] = {1'b0, back};
            b[1][c] = 4'h1;
            b[6][c] = 4'h9;
            b[7][c] = {1'b1, back};
        end
        return b;
    endfunction

    for (genvar i = 0; i < 64; i++) begin : g_own
        assign own_mask[i] = (board[i / 8][i % 8] != 4'd0) && (board[i / 8][i % 8][3] == turn);
    end

    assign click_code   = board[bus.click_pos[5:3]][bus.click_pos[2:0]];
    assign click_own    = own_mask[bus.click_pos];
    assign click_accept = bus.click_valid && bus.click_ready;

    // Pawns promote on the far rank of their own colour.
    assign promote     = (src_code[2:0] == 3'd1) &&
                         ((!src_code[3] && dst_pos[5:3] == 3'd7) || (src_code[3] && dst_pos[5:3] == 3'd0));
    assign commit_code = promote ? {src_code[3], PROMO_TYPE} : src_code;

    assign bus.click_ready     = (state == ST_WAIT_SRC) || (state == ST_WAIT_DST);
    assign bus.selected_figure = sel_figure;
    assign bus.position        = sel_position;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_WAIT_SRC;
            board        <= initial_board();
            turn         <= 1'b0;
            move_count   <= 8'd0;
            move_mask    <= 64'd0;
            move_done    <= 1'b0;
            illegal      <= 1'b0;
            src_pos      <= 6'd0;
            src_code     <= 4'd0;
            dst_pos      <= 6'd0;
            eval_cnt     <= 4'd0;
            sel_figure   <= 5'd0;
            sel_position <= 6'd0;
        end else begin
            move_done <= 1'b0;
            illegal   <= 1'b0;
            if (new_game) begin
                state        <= ST_WAIT_SRC;
                board        <= initial_board();
                turn         <= 1'b0;
                move_count   <= 8'd0;
                move_mask    <= 64'd0;
                sel_figure   <= 5'd0;
                sel_position <= 6'd0;
            end else begin
                case (state)
                    ST_WAIT_SRC: begin
                        if (click_accept) begin
                            if (click_own) begin
                                src_pos      <= bus.click_pos;
                                src_code     <= click_code;
                                sel_figure   <= {1'b0, click_code};
                                sel_position <= bus.click_pos;
                                eval_cnt     <= EVAL_LOAD;
                                state        <= ST_EVAL;
                            end else begin
                                illegal <= 1'b1;
                            end
                        end
                    end
                    ST_EVAL: begin
                        if (eval_cnt == 4'd0) begin
                            move_mask <= bus.possible_moves & ~own_mask;
                            state     <= ST_WAIT_DST;
                        end else begin
                            eval_cnt <= eval_cnt - 4'd1;
                        end
                    end
                    ST_WAIT_DST: begin
                        if (click_accept) begin
                            if (bus.click_pos == src_pos) begin
                                move_mask    <= 64'd0;
                                sel_figure   <= 5'd0;
                                sel_position <= 6'd0;
                                state        <= ST_WAIT_SRC;
                            end else if (click_own) begin
                                src_pos      <= bus.click_pos;
                                src_code     <= click_code;
                                sel_figure   <= {1'b0, click_code};
                                sel_position <= bus.click_pos;
                                eval_cnt     <= EVAL_LOAD;
                                move_mask    <= 64'd0;
                                state        <= ST_EVAL;
                            end else if (move_mask[bus.click_pos]) begin
                                dst_pos   <= bus.click_pos;
                                move_mask <= 64'd0;
                                state     <= ST_COMMIT;
                            end else begin
                                illegal <= 1'b1;
                            end
                        end
                    end
                    ST_COMMIT: begin
                        // Source clear and destination write land on the same edge.
                        board[dst_pos[5:3]][dst_pos[2:0]] <= commit_code;
                        board[src_pos[5:3]][src_pos[2:0]] <= 4'd0;
                        turn         <= ~turn;
                        move_count   <= move_count + 8'd1;
                        sel_figure   <= 5'd0;
                        sel_position <= 6'd0;
                        move_done    <= 1'b1;
                        state        <= ST_WAIT_SRC;
                    end
                    default: state <= ST_WAIT_SRC;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_move_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_move_controller
// Brief    : Directed self-checking bench for move_controller
// Revision : 1.0
// ============================================================================
module tb_move_controller;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 new_game;
    logic [7:0][7:0][3:0] board;
    logic [63:0]          move_mask;
    logic                 turn;
    logic                 move_done;
    logic                 illegal;
    logic [7:0]           move_count;

    logic [7:0][7:0][3:0] init_exp;
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    move_controller_if bus ();

    move_controller #(
        .EVAL_CYCLES (1),
        .PROMO_TYPE  (3'd5)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .new_game   (new_game),
        .bus        (bus),
        .board      (board),
        .move_mask  (move_mask),
        .turn       (turn),
        .move_done  (move_done),
        .illegal    (illegal),
        .move_count (move_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_new_game();
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
    endtask

    task automatic click(input logic [5:0] p);
        int n = 0;
        while (bus.click_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        total++;
        if (bus.click_ready !== 1'b1) begin
            $display("FAIL click_ready_wait got=%b exp=1", bus.click_ready);
            bad++;
        end
        bus.click_valid = 1'b1;
        bus.click_pos   = p;
        tick();
        bus.click_valid = 1'b0;
    endtask

    task automatic do_move(input logic [5:0] src, input logic [5:0] dst);
        bus.possible_moves = 64'd1 << dst;
        click(src);
        click(dst);
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        total++; if (board !== init_exp) begin $display("FAIL reset_board got=%h exp=%h", board, init_exp); bad++; end
        total++; if (turn !== 1'b0) begin $display("FAIL reset_turn got=%b exp=0", turn); bad++; end
        total++; if (move_count !== 8'd0) begin $display("FAIL reset_count got=%0d exp=0", move_count); bad++; end
        total++; if (move_mask !== 64'd0) begin $display("FAIL reset_mask got=%h exp=0", move_mask); bad++; end
        total++; if (bus.selected_figure !== 5'd0) begin $display("FAIL reset_sel got=%h exp=0", bus.selected_figure); bad++; end
        total++; if (bus.click_ready !== 1'b1) begin $display("FAIL reset_ready got=%b exp=1", bus.click_ready); bad++; end
        total++; if ({move_done, illegal} !== 2'b00) begin $display("FAIL reset_pulses got=%b exp=00", {move_done, illegal}); bad++; end
    endtask

    task automatic test_first_move();
        bus.possible_moves = 64'd1 << 28;
        click(6'h0C);
        total++; if (bus.selected_figure !== 5'h01) begin $display("FAIL fm_sel got=%h exp=01", bus.selected_figure); bad++; end
        total++; if (bus.position !== 6'h0C) begin $display("FAIL fm_pos got=%h exp=0c", bus.position); bad++; end
        total++; if (bus.click_ready !== 1'b0) begin $display("FAIL fm_eval_ready got=%b exp=0", bus.click_ready); bad++; end
        tick();
        total++; if (move_mask !== (64'd1 << 28)) begin $display("FAIL fm_mask got=%h exp=%h", move_mask, 64'd1 << 28); bad++; end
        click(6'h1C);
        total++; if (board[1][4] !== 4'h1) begin $display("FAIL fm_precommit got=%h exp=1", board[1][4]); bad++; end
        tick();
        total++; if (board[3][4] !== 4'h1) begin $display("FAIL fm_dst got=%h exp=1", board[3][4]); bad++; end
        total++; if (board[1][4] !== 4'h0) begin $display("FAIL fm_src got=%h exp=0", board[1][4]); bad++; end
        total++; if (turn !== 1'b1) begin $display("FAIL fm_turn got=%b exp=1", turn); bad++; end
        total++; if (move_count !== 8'd1) begin $display("FAIL fm_count got=%0d exp=1", move_count); bad++; end
        total++; if (move_done !== 1'b1) begin $display("FAIL fm_done got=%b exp=1", move_done); bad++; end
        tick();
        total++; if (move_done !== 1'b0) begin $display("FAIL fm_done_width got=%b exp=0", move_done); bad++; end
    endtask

    task automatic test_illegal_src();
        pulse_new_game();
        click(6'h34);
        total++; if (illegal !== 1'b1) begin $display("FAIL ill_pulse got=%b exp=1", illegal); bad++; end
        total++; if (bus.click_ready !== 1'b1) begin $display("FAIL ill_state got=%b exp=1", bus.click_ready); bad++; end
        total++; if (bus.selected_figure !== 5'd0) begin $display("FAIL ill_sel got=%h exp=0", bus.selected_figure); bad++; end
        total++; if (board !== init_exp) begin $display("FAIL ill_board got=%h exp=%h", board, init_exp); bad++; end
        tick();
        total++; if (illegal !== 1'b0) begin $display("FAIL ill_width got=%b exp=0", illegal); bad++; end
    endtask

    task automatic test_reselect();
        logic [63:0] exp_mask;
        exp_mask = (64'd1 << 16) | (64'd1 << 18);
        bus.possible_moves = exp_mask | (64'd1 << 11);
        click(6'h01);
        total++; if (bus.selected_figure !== 5'h03) begin $display("FAIL rs_knight got=%h exp=03", bus.selected_figure); bad++; end
        tick();
        total++; if (move_mask !== exp_mask) begin $display("FAIL rs_filter got=%h exp=%h", move_mask, exp_mask); bad++; end
        click(6'h0B);
        total++; if (bus.selected_figure !== 5'h01) begin $display("FAIL rs_sel got=%h exp=01", bus.selected_figure); bad++; end
        total++; if (bus.position !== 6'h0B) begin $display("FAIL rs_pos got=%h exp=0b", bus.position); bad++; end
        total++; if (move_mask !== 64'd0) begin $display("FAIL rs_mask_eval got=%h exp=0", move_mask); bad++; end
        total++; if (illegal !== 1'b0) begin $display("FAIL rs_no_illegal got=%b exp=0", illegal); bad++; end
        tick();
        total++; if (move_mask !== exp_mask) begin $display("FAIL rs_mask2 got=%h exp=%h", move_mask, exp_mask); bad++; end
        click(6'h20);
        total++; if (illegal !== 1'b1) begin $display("FAIL rs_bad_dst got=%b exp=1", illegal); bad++; end
        total++; if (move_mask !== exp_mask) begin $display("FAIL rs_mask_kept got=%h exp=%h", move_mask, exp_mask); bad++; end
        total++; if (bus.click_ready !== 1'b1) begin $display("FAIL rs_stay got=%b exp=1", bus.click_ready); bad++; end
        click(6'h0B);
        total++; if (bus.selected_figure !== 5'd0) begin $display("FAIL rs_cleanup got=%h exp=0", bus.selected_figure); bad++; end
    endtask

    task automatic test_deselect();
        bus.possible_moves = 64'd1 << 28;
        click(6'h0C);
        tick();
        click(6'h0C);
        total++; if (bus.selected_figure !== 5'd0) begin $display("FAIL ds_sel got=%h exp=0", bus.selected_figure); bad++; end
        total++; if (move_mask !== 64'd0) begin $display("FAIL ds_mask got=%h exp=0", move_mask); bad++; end
        total++; if (illegal !== 1'b0) begin $display("FAIL ds_illegal got=%b exp=0", illegal); bad++; end
        total++; if (turn !== 1'b0) begin $display("FAIL ds_turn got=%b exp=0", turn); bad++; end
        total++; if (board !== init_exp) begin $display("FAIL ds_board got=%h exp=%h", board, init_exp); bad++; end
    endtask

    task automatic test_promotion();
        pulse_new_game();
        do_move(6'h08, 6'h30);
        total++; if (board[6][0] !== 4'h1) begin $display("FAIL pr_capture got=%h exp=1", board[6][0]); bad++; end
        total++; if (board[1][0] !== 4'h0) begin $display("FAIL pr_src got=%h exp=0", board[1][0]); bad++; end
        do_move(6'h38, 6'h28);
        total++; if (board[5][0] !== 4'hA) begin $display("FAIL pr_black got=%h exp=a", board[5][0]); bad++; end
        do_move(6'h30, 6'h38);
        total++; if (board[7][0] !== 4'h5) begin $display("FAIL pr_queen got=%h exp=5", board[7][0]); bad++; end
        total++; if (board[6][0] !== 4'h0) begin $display("FAIL pr_vacate got=%h exp=0", board[6][0]); bad++; end
        total++; if (move_count !== 8'd3) begin $display("FAIL pr_count got=%0d exp=3", move_count); bad++; end
    endtask

    task automatic test_reset_mid_eval();
        pulse_new_game();
        do_move(6'h0C, 6'h1C);
        bus.possible_moves = 64'd1 << 36;
        click(6'h34);
        rst_n = 1'b0;
        #2;
        total++; if (board !== init_exp) begin $display("FAIL rme_board got=%h exp=%h", board, init_exp); bad++; end
        total++; if (turn !== 1'b0) begin $display("FAIL rme_turn got=%b exp=0", turn); bad++; end
        total++; if (move_count !== 8'd0) begin $display("FAIL rme_count got=%0d exp=0", move_count); bad++; end
        total++; if (bus.selected_figure !== 5'd0) begin $display("FAIL rme_sel got=%h exp=0", bus.selected_figure); bad++; end
        tick();
        rst_n = 1'b1;
        tick();
        total++; if (bus.click_ready !== 1'b1) begin $display("FAIL rme_ready got=%b exp=1", bus.click_ready); bad++; end
    endtask

    task automatic test_new_game_priority();
        do_move(6'h0C, 6'h1C);
        bus.possible_moves = 64'd1 << 36;
        click(6'h34);
        tick();
        total++; if (move_mask !== (64'd1 << 36)) begin $display("FAIL ng_mask_pre got=%h exp=%h", move_mask, 64'd1 << 36); bad++; end
        new_game        = 1'b1;
        bus.click_valid = 1'b1;
        bus.click_pos   = 6'h24;
        tick();
        new_game        = 1'b0;
        bus.click_valid = 1'b0;
        total++; if (board !== init_exp) begin $display("FAIL ng_board got=%h exp=%h", board, init_exp); bad++; end
        total++; if (turn !== 1'b0) begin $display("FAIL ng_turn got=%b exp=0", turn); bad++; end
        total++; if (move_count !== 8'd0) begin $display("FAIL ng_count got=%0d exp=0", move_count); bad++; end
        total++; if (move_mask !== 64'd0) begin $display("FAIL ng_mask got=%h exp=0", move_mask); bad++; end
        total++; if (bus.selected_figure !== 5'd0) begin $display("FAIL ng_sel got=%h exp=0", bus.selected_figure); bad++; end
        tick();
        total++; if (move_done !== 1'b0) begin $display("FAIL ng_no_commit got=%b exp=0", move_done); bad++; end
        total++; if (board !== init_exp) begin $display("FAIL ng_board2 got=%h exp=%h", board, init_exp); bad++; end
    endtask

    task automatic test_count_wrap();
        pulse_new_game();
        for (int i = 0; i < 256; i++) begin
            if (i == 255) begin
                total++; if (move_count !== 8'd255) begin $display("FAIL wrap_255 got=%0d exp=255", move_count); bad++; end
            end
            case (i % 4)
                0:       do_move(6'h01, 6'h10);
                1:       do_move(6'h39, 6'h28);
                2:       do_move(6'h10, 6'h01);
                default: do_move(6'h28, 6'h39);
            endcase
        end
        total++; if (move_count !== 8'd0) begin $display("FAIL wrap_zero got=%0d exp=0", move_count); bad++; end
        total++; if (turn !== 1'b0) begin $display("FAIL wrap_turn got=%b exp=0", turn); bad++; end
        total++; if (board !== init_exp) begin $display("FAIL wrap_board got=%h exp=%h", board, init_exp); bad++; end
    endtask

    initial begin
        logic [3:0] back [8];
        back = '{4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h4, 4'h3, 4'h2};
        init_exp = '0;
        for (int c = 0; c < 8; c++) begin
            init_exp[0][c] = back[c];
            init_exp[1][c] = 4'h1;
            init_exp[6][c] = 4'h9;
            init_exp[7][c] = back[c] | 4'h8;
        end

        rst_n              = 1'b0;
        new_game           = 1'b0;
        bus.click_valid    = 1'b0;
        bus.click_pos      = 6'd0;
        bus.possible_moves = 64'd0;

        test_reset();
        test_first_move();
        test_illegal_src();
        test_reselect();
        test_deselect();
        test_promotion();
        test_reset_mid_eval();
        test_new_game_priority();
        test_count_wrap();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
